// File: rtl/foo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : foo_pkg
// Purpose  : Shared types and constants for the foo instance server.
//            Holds the request opcode and response status encodings, the FSM
//            state encoding and the default operand/state width.
// Revision : 1.0  initial release
// ============================================================================
package foo_pkg;

  // Default operand/state/result width
  localparam int FOO_DATA_W = 64;

  // Request opcode (2 bits on the wire)
  typedef enum logic [1:0] {
    FOO_OP_CREATE = 2'd0,
    FOO_OP_EVAL   = 2'd1,
    FOO_OP_FINAL  = 2'd2,
    FOO_OP_RSVD   = 2'd3
  } foo_op_e;

  // Response status (2 bits on the wire)
  typedef enum logic [1:0] {
    FOO_ST_OK         = 2'd0,
    FOO_ST_NO_SLOT    = 2'd1,
    FOO_ST_BAD_HANDLE = 2'd2,
    FOO_ST_BAD_OP     = 2'd3
  } foo_status_e;

  // Server request-processing FSM
  typedef enum logic [1:0] {
    FOO_FSM_IDLE = 2'd0,
    FOO_FSM_EXEC = 2'd1,
    FOO_FSM_RESP = 2'd2
  } foo_fsm_e;

endpackage : foo_pkg
`default_nettype wire

// File: rtl/foo_slot_alloc.sv
`default_nettype none
// ============================================================================
// Module   : foo_slot_alloc
// Purpose  : Combinational priority encoder returning the lowest-index free
//            slot in a live bitmap.
// Ports    : i_live      in  NUM_SLOTS  bit i set = slot i is live
//            o_free_idx  out HANDLE_W   lowest free slot (0 when none free)
//            o_any_free  out 1          at least one slot is free
// Revision : 1.0  initial release
// ============================================================================
module foo_slot_alloc #(
  parameter int NUM_SLOTS = 4,
  parameter int HANDLE_W  = 2
) (
  input  logic [NUM_SLOTS-1:0] i_live,
  output logic [HANDLE_W-1:0]  o_free_idx,
  output logic                 o_any_free
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    o_free_idx = '0;
    o_any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!i_live[i]) begin
        o_free_idx = HANDLE_W'(i);
        o_any_free = 1'b1;
      end
    end
  end

endmodule : foo_slot_alloc
`default_nettype wire

// File: rtl/foo_instance_server.sv
`default_nettype none
// ============================================================================
// Module   : foo_instance_server
// Purpose  : Responder for the foo black-box call interface. Serves CREATE,
//            EVAL and FINAL requests against per-instance accumulator slots.
//            One request in flight: IDLE (accept) -> EXEC -> RESP -> IDLE.
// Ports    : clk, rst                    clock / async active-high reset
//            req_valid/req_ready         request handshake
//            req_op, req_handle, req_a   request fields (sampled at accept)
//            rsp_valid/rsp_ready         response handshake
//            rsp_status, rsp_handle,
//            rsp_x                       response fields (stable in RESP)
//            live_count                  number of live handles
// Revision : 1.0  initial release
// ============================================================================
module foo_instance_server
  import foo_pkg::*;
#(
  parameter  int NUM_SLOTS = 4,
  parameter  int DATA_W    = FOO_DATA_W,
  localparam int HANDLE_W  = $clog2(NUM_SLOTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [HANDLE_W-1:0] req_handle,
  input  logic [DATA_W-1:0]   req_a,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_status,
  output logic [HANDLE_W-1:0] rsp_handle,
  output logic [DATA_W-1:0]   rsp_x,
  output logic [HANDLE_W:0]   live_count
);

  localparam logic [HANDLE_W:0] c_cnt_one   = (HANDLE_W+1)'(1);
  localparam logic [HANDLE_W:0] c_num_slots = (HANDLE_W+1)'(NUM_SLOTS);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  foo_fsm_e              r_fsm;
  foo_fsm_e              w_fsm_next;

  foo_op_e               r_op;
  logic [HANDLE_W-1:0]   r_handle;
  logic [DATA_W-1:0]     r_a;

  logic [NUM_SLOTS-1:0]  r_live;
  logic [DATA_W-1:0]     r_state [NUM_SLOTS];
  logic [HANDLE_W:0]     r_live_count;

  foo_status_e           r_rsp_status;
  logic [HANDLE_W-1:0]   r_rsp_handle;
  logic [DATA_W-1:0]     r_rsp_x;

  logic                  w_accept;

  // --------------------------------------------------------------------------
  // Free-slot lookup
  // --------------------------------------------------------------------------
  logic [HANDLE_W-1:0]   w_free_idx;
  logic                  w_any_free;

  foo_slot_alloc #(
    .NUM_SLOTS (NUM_SLOTS),
    .HANDLE_W  (HANDLE_W)
  ) u_slot_alloc (
    .i_live     (r_live),
    .o_free_idx (w_free_idx),
    .o_any_free (w_any_free)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm <= FOO_FSM_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_fsm_next = r_fsm;
    // The state register already sits in IDLE during reset; gate with rst so
    // the requester never sees ready while the server is held in reset.
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (r_fsm)
      FOO_FSM_IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          w_fsm_next = FOO_FSM_EXEC;
        end
      end
      FOO_FSM_EXEC: begin
        w_fsm_next = FOO_FSM_RESP;
      end
      FOO_FSM_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_fsm_next = FOO_FSM_IDLE;
        end
      end
      default: begin
        w_fsm_next = FOO_FSM_IDLE;
      end
    endcase
  end

  assign w_accept = req_valid & req_ready;

  // --------------------------------------------------------------------------
  // Operation decode (evaluated against captured request; used in EXEC)
  // --------------------------------------------------------------------------
  logic                w_handle_ok;
  logic                w_hit;
  logic [DATA_W-1:0]   w_cur_state;
  foo_status_e         w_status;
  logic [HANDLE_W-1:0] w_rsp_handle;
  logic [DATA_W-1:0]   w_rsp_x;
  logic                w_wr_en;
  logic [HANDLE_W-1:0] w_wr_idx;
  logic [DATA_W-1:0]   w_wr_val;
  logic                w_set_live;
  logic                w_clr_live;

  // Only relevant when NUM_SLOTS is not a power of two.
  assign w_handle_ok = ({1'b0, r_handle} < c_num_slots);
  assign w_hit       = w_handle_ok && r_live[r_handle];
  assign w_cur_state = w_handle_ok ? r_state[r_handle] : '0;

  always_comb begin
    w_status     = FOO_ST_OK;
    w_rsp_handle = r_handle;
    w_rsp_x      = '0;
    w_wr_en      = 1'b0;
    w_wr_idx     = r_handle;
    w_wr_val     = '0;
    w_set_live   = 1'b0;
    w_clr_live   = 1'b0;
    unique case (r_op)
      FOO_OP_CREATE: begin
        if (w_any_free) begin
          w_rsp_handle = w_free_idx;
          w_wr_en      = 1'b1;
          w_wr_idx     = w_free_idx;
          w_set_live   = 1'b1;
        end else begin
          w_status     = FOO_ST_NO_SLOT;
          w_rsp_handle = '0;
        end
      end
      FOO_OP_EVAL: begin
        if (w_hit) begin
          // Carry out of the top bit is intentionally dropped.
          w_wr_val = w_cur_state + r_a;
          w_wr_en  = 1'b1;
          w_rsp_x  = w_wr_val;
        end else begin
          w_status = FOO_ST_BAD_HANDLE;
        end
      end
      FOO_OP_FINAL: begin
        if (w_hit) begin
          w_rsp_x    = w_cur_state;
          w_wr_en    = 1'b1;
          w_clr_live = 1'b1;
        end else begin
          w_status = FOO_ST_BAD_HANDLE;
        end
      end
      default: begin
        w_status = FOO_ST_BAD_OP;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= FOO_OP_CREATE;
      r_handle     <= '0;
      r_a          <= '0;
      r_live       <= '0;
      r_live_count <= '0;
      r_rsp_status <= FOO_ST_OK;
      r_rsp_handle <= '0;
      r_rsp_x      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_op     <= foo_op_e'(req_op);
        r_handle <= req_handle;
        r_a      <= req_a;
      end
      if (r_fsm == FOO_FSM_EXEC) begin
        r_rsp_status <= w_status;
        r_rsp_handle <= w_rsp_handle;
        r_rsp_x      <= w_rsp_x;
        if (w_wr_en) begin
          r_state[w_wr_idx] <= w_wr_val;
        end
        if (w_set_live) begin
          r_live[w_wr_idx] <= 1'b1;
          r_live_count     <= r_live_count + c_cnt_one;
        end else if (w_clr_live) begin
          r_live[w_wr_idx] <= 1'b0;
          r_live_count     <= r_live_count - c_cnt_one;
        end
      end
    end
  end

  assign rsp_status = r_rsp_status;
  assign rsp_handle = r_rsp_handle;
  assign rsp_x      = r_rsp_x;
  assign live_count = r_live_count;

endmodule : foo_instance_server
`default_nettype wire

// File: tb/tb_foo_instance_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_foo_instance_server
// Purpose  : Directed self-checking bench for foo_instance_server.
// Revision : 1.0  initial release
// ============================================================================
module tb_foo_instance_server;

  localparam logic [1:0] c_create = 2'd0;
  localparam logic [1:0] c_eval   = 2'd1;
  localparam logic [1:0] c_final  = 2'd2;
  localparam logic [1:0] c_rsvd   = 2'd3;
  localparam logic [1:0] c_ok     = 2'd0;
  localparam logic [1:0] c_noslot = 2'd1;
  localparam logic [1:0] c_badh   = 2'd2;
  localparam logic [1:0] c_badop  = 2'd3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_handle;
  logic [63:0] req_a;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [1:0]  rsp_handle;
  logic [63:0] rsp_x;
  logic [2:0]  live_count;

  int r_checks = 0;
  int r_errors = 0;

  foo_instance_server #(
    .NUM_SLOTS (4),
    .DATA_W    (64)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_handle (req_handle),
    .req_a      (req_a),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_handle (rsp_handle),
    .rsp_x      (rsp_x),
    .live_count (live_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    r_checks++;
    if (obs !== exp) begin
      r_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full request/response transaction; returns the response fields.
  task automatic do_op(input logic [1:0] op, input logic [1:0] h, input logic [63:0] a,
                       output logic [1:0] st, output logic [1:0] rh, output logic [63:0] x);
    int n;
    st = '0; rh = '0; x = '0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_handle = h; req_a = a;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble request fields; they must not be sampled outside accept.
    req_valid = 1'b0; req_op = c_rsvd; req_handle = 2'd3; req_a = '1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    if (!rsp_valid) begin
      check("rsp_valid_timeout", 64'd0, 64'd1);
      return;
    end
    check("rsp_latency", 64'(n), 64'd2);
    st = rsp_status; rh = rsp_handle; x = rsp_x;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic expect_op(input string tag, input logic [1:0] op, input logic [1:0] h,
                           input logic [63:0] a, input logic [1:0] e_st,
                           input logic [1:0] e_h, input logic [63:0] e_x);
    logic [1:0]  st;
    logic [1:0]  rh;
    logic [63:0] x;
    do_op(op, h, a, st, rh, x);
    check({tag, "_status"}, 64'(st), 64'(e_st));
    check({tag, "_handle"}, 64'(rh), 64'(e_h));
    check({tag, "_x"}, x, e_x);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_live_count", 64'(live_count), 64'd0);
    check("rst_rsp_status", 64'(rsp_status), 64'(c_ok));
    check("rst_rsp_handle", 64'(rsp_handle), 64'd0);
    check("rst_rsp_x", rsp_x, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  snap_st;
    logic [1:0]  snap_h;
    logic [63:0] snap_x;
    int          n;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_handle = '0; req_a = '0;
    rsp_ready = 1'b0;
    apply_reset();

    // Fill all slots, then overflow
    expect_op("create0", c_create, 2'd3, 64'd0, c_ok, 2'd0, 64'd0);
    expect_op("create1", c_create, 2'd0, 64'd0, c_ok, 2'd1, 64'd0);
    expect_op("create2", c_create, 2'd0, 64'd0, c_ok, 2'd2, 64'd0);
    expect_op("create3", c_create, 2'd0, 64'd0, c_ok, 2'd3, 64'd0);
    check("count_full", 64'(live_count), 64'd4);
    expect_op("create4", c_create, 2'd2, 64'd0, c_noslot, 2'd0, 64'd0);
    check("count_after_noslot", 64'(live_count), 64'd4);

    // Accumulate then finalize
    apply_reset();
    expect_op("c_h0", c_create, 2'd0, 64'd0, c_ok, 2'd0, 64'd0);
    expect_op("eval5", c_eval, 2'd0, 64'd5, c_ok, 2'd0, 64'd5);
    expect_op("eval7", c_eval, 2'd0, 64'd7, c_ok, 2'd0, 64'd12);
    expect_op("final_h0", c_final, 2'd0, 64'd0, c_ok, 2'd0, 64'd12);
    check("count_after_final", 64'(live_count), 64'd0);

    // Wraparound: state 2 + all-ones = 1
    expect_op("c_h0b", c_create, 2'd0, 64'd0, c_ok, 2'd0, 64'd0);
    expect_op("eval2", c_eval, 2'd0, 64'd2, c_ok, 2'd0, 64'd2);
    expect_op("eval_wrap", c_eval, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, c_ok, 2'd0, 64'd1);

    // Double final, eval on freed handle, handle reuse
    expect_op("c_h1", c_create, 2'd0, 64'd0, c_ok, 2'd1, 64'd0);
    expect_op("eval_h1", c_eval, 2'd1, 64'd9, c_ok, 2'd1, 64'd9);
    expect_op("final_h1", c_final, 2'd1, 64'd0, c_ok, 2'd1, 64'd9);
    expect_op("final_h1_again", c_final, 2'd1, 64'd0, c_badh, 2'd1, 64'd0);
    expect_op("eval_freed", c_eval, 2'd1, 64'd4, c_badh, 2'd1, 64'd0);
    expect_op("eval_never", c_eval, 2'd3, 64'd4, c_badh, 2'd3, 64'd0);
    expect_op("reuse_h1", c_create, 2'd0, 64'd0, c_ok, 2'd1, 64'd0);
    check("count_two", 64'(live_count), 64'd2);

    // Backpressure: EVAL h0 a=3 (state 1 -> 4), hold rsp_ready low 10 cycles
    @(negedge clk);
    req_valid = 1'b1; req_op = c_eval; req_handle = 2'd0; req_a = 64'd3;
    check("bp_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    // Keep a CREATE request pending; it must not be taken while busy
    req_op = c_create; req_handle = 2'd2; req_a = 64'd77;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    snap_st = rsp_status; snap_h = rsp_handle; snap_x = rsp_x;
    check("bp_x", snap_x, 64'd4);
    check("bp_status", 64'(snap_st), 64'(c_ok));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_ctl", 64'({rsp_valid, req_ready, rsp_status, rsp_handle}),
            64'({1'b1, 1'b0, snap_st, snap_h}));
      check("bp_hold_x", rsp_x, snap_x);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_count_unchanged", 64'(live_count), 64'd2);

    // Reserved opcode
    expect_op("bad_op", c_rsvd, 2'd2, 64'd55, c_badop, 2'd2, 64'd0);
    check("count_after_badop", 64'(live_count), 64'd2);

    // Reset during EXEC of an EVAL
    @(negedge clk);
    req_valid = 1'b1; req_op = c_eval; req_handle = 2'd1; req_a = 64'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_count", 64'(live_count), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("midrst_no_rsp", 64'(n), 64'd0);
    expect_op("post_rst_create", c_create, 2'd0, 64'd0, c_ok, 2'd0, 64'd0);
    check("post_rst_count", 64'(live_count), 64'd1);
    expect_op("post_rst_eval_h1", c_eval, 2'd1, 64'd1, c_badh, 2'd1, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_foo_instance_server
`default_nettype wire
